// File: rtl/usb_fs_nb_in_ep_supply.sv
// Per-endpoint IN packet supplier for the non-buffered USB full-speed IN
// protocol engine. Software commits packet descriptors (buffer id, size,
// ready) per endpoint; the engine fetches bytes by offset from the shared
// packet SRAM, then retires the packet (good end) or keeps it for resend
// (rollback). A USB bus reset cancels every ready packet into a pending flag.
//
// Strobe semantics: every *_we / *_starting / *_end / *_rollback / *_reset
// input is a single-cycle strobe, sampled on the rising clock edge, with no
// back-pressure. cfg_err_o and pkt_sent_o are one-cycle pulses that are
// asserted in the cycle after the strobe that caused them.
module usb_fs_nb_in_ep_supply #(
  parameter int NumInEps         = 12,
  parameter int MaxInPktSizeByte = 32,
  parameter int NumBuffers       = 32,
  localparam int PktW = $clog2(MaxInPktSizeByte),
  localparam int BufW = $clog2(NumBuffers)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_i,
  input  logic                 link_reset_i,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_ep_i,
  input  logic [BufW-1:0]      cfg_buffer_i,
  input  logic [PktW:0]        cfg_size_i,
  input  logic                 cfg_rdy_i,
  output logic                 cfg_err_o,
  output logic [NumInEps-1:0]  ep_rdy_o,
  output logic [NumInEps-1:0]  ep_sent_o,
  output logic [NumInEps-1:0]  ep_pend_o,
  input  logic [NumInEps-1:0]  sent_clr_i,
  input  logic [NumInEps-1:0]  pend_clr_i,
  input  logic                 in_xact_starting_i,
  input  logic [3:0]           in_xact_start_ep_i,
  input  logic [3:0]           in_ep_current_i,
  input  logic                 in_ep_rollback_i,
  input  logic                 in_ep_xact_end_i,
  input  logic [PktW-1:0]      in_ep_get_addr_i,
  output logic [NumInEps-1:0]  in_ep_has_data_o,
  output logic [7:0]           in_ep_data_o,
  output logic [NumInEps-1:0]  in_ep_data_done_o,
  output logic                 mem_req_o,
  output logic [BufW+PktW-1:0] mem_addr_o,
  input  logic [7:0]           mem_rdata_i,
  output logic                 pkt_sent_o,
  output logic [3:0]           pkt_sent_ep_o
);

  localparam logic [3:0] EpLimit = 4'(NumInEps);
  localparam logic [PktW:0] MaxSize = (PktW+1)'(MaxInPktSizeByte);

  logic [BufW-1:0] buf_q [NumInEps];
  logic [BufW-1:0] buf_d [NumInEps];
  logic [PktW:0]   size_q [NumInEps];
  logic [PktW:0]   size_d [NumInEps];
  logic [NumInEps-1:0] rdy_q, rdy_d;
  logic [NumInEps-1:0] busy_q, busy_d;
  logic [NumInEps-1:0] sent_q, sent_d;
  logic [NumInEps-1:0] pend_q, pend_d;
  logic       cfg_err_q, cfg_err_d;
  logic       pkt_sent_q, pkt_sent_d;
  logic [3:0] pkt_sent_ep_q, pkt_sent_ep_d;

  logic          cfg_ok, cur_ok, start_ok;
  logic [PktW:0] size_sat;

  assign cfg_ok   = cfg_ep_i < EpLimit;
  assign cur_ok   = in_ep_current_i < EpLimit;
  assign start_ok = in_xact_start_ep_i < EpLimit;
  assign size_sat = (cfg_size_i > MaxSize) ? MaxSize : cfg_size_i;

  // Next-state: link reset dominates; otherwise start, config write and
  // transaction end/rollback are applied in that order so end/rollback win.
  always_comb begin
    buf_d         = buf_q;
    size_d        = size_q;
    rdy_d         = rdy_q;
    busy_d        = busy_q;
    sent_d        = sent_q & ~sent_clr_i;
    pend_d        = pend_q & ~pend_clr_i;
    cfg_err_d     = 1'b0;
    pkt_sent_d    = 1'b0;
    pkt_sent_ep_d = pkt_sent_ep_q;
    if (link_reset_i) begin
      pend_d = pend_q | rdy_q;
      rdy_d  = '0;
      busy_d = '0;
    end else begin
      // busy follows the pre-write rdy, so a same-cycle write cannot arm it
      if (in_xact_starting_i && start_ok && rdy_q[in_xact_start_ep_i]) begin
        busy_d[in_xact_start_ep_i] = 1'b1;
      end
      if (cfg_we_i) begin
        if (cfg_ok && !busy_q[cfg_ep_i]) begin
          buf_d[cfg_ep_i]  = cfg_buffer_i;
          size_d[cfg_ep_i] = size_sat;
          rdy_d[cfg_ep_i]  = cfg_rdy_i;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      if (cur_ok && (in_ep_xact_end_i || in_ep_rollback_i)) begin
        busy_d[in_ep_current_i] = 1'b0;
        if (in_ep_xact_end_i) begin
          rdy_d[in_ep_current_i]  = 1'b0;
          sent_d[in_ep_current_i] = 1'b1;
          pkt_sent_d              = 1'b1;
          pkt_sent_ep_d           = in_ep_current_i;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_48mhz_i) begin
    if (rst_i) begin
      buf_q         <= '{default: '0};
      size_q        <= '{default: '0};
      rdy_q         <= '0;
      busy_q        <= '0;
      sent_q        <= '0;
      pend_q        <= '0;
      cfg_err_q     <= 1'b0;
      pkt_sent_q    <= 1'b0;
      pkt_sent_ep_q <= 4'd0;
    end else begin
      buf_q         <= buf_d;
      size_q        <= size_d;
      rdy_q         <= rdy_d;
      busy_q        <= busy_d;
      sent_q        <= sent_d;
      pend_q        <= pend_d;
      cfg_err_q     <= cfg_err_d;
      pkt_sent_q    <= pkt_sent_d;
      pkt_sent_ep_q <= pkt_sent_ep_d;
    end
  end

  // Offset-reached flags; a size of 0 reports done at offset 0.
  always_comb begin
    in_ep_data_done_o = '0;
    for (int i = 0; i < NumInEps; i++) begin
      in_ep_data_done_o[i] = ({1'b0, in_ep_get_addr_i} >= size_q[i]);
    end
  end

  // Fetch path: SRAM address from the current endpoint's buffer; data is
  // passed through unregistered and lands one cycle after its offset.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = {{BufW{1'b0}}, in_ep_get_addr_i};
    if (cur_ok) begin
      mem_req_o  = rdy_q[in_ep_current_i];
      mem_addr_o = {buf_q[in_ep_current_i], in_ep_get_addr_i};
    end
  end

  // End and rollback of the same transaction are mutually exclusive.
  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_i) begin
      assert (!(in_ep_xact_end_i && in_ep_rollback_i));
    end
  end

  assign in_ep_data_o     = mem_rdata_i;
  assign in_ep_has_data_o = rdy_q;
  assign ep_rdy_o         = rdy_q;
  assign ep_sent_o        = sent_q;
  assign ep_pend_o        = pend_q;
  assign cfg_err_o        = cfg_err_q;
  assign pkt_sent_o       = pkt_sent_q;
  assign pkt_sent_ep_o    = pkt_sent_ep_q;

endmodule
